// File: rtl/dot_product_stream_engine.sv
// Streaming multi-lane dot-product engine: accumulates cfg_len beats of LANES element pairs
// and queues each finished sum in a small result FIFO drained over valid/ready.
module dot_product_stream_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int LANES        = 2,
    parameter int MAX_LEN      = 16,
    parameter int LEN_WIDTH    = $clog2(MAX_LEN + 1),
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(LANES * MAX_LEN),
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [LEN_WIDTH-1:0]             cfg_len,
    input  logic                             cfg_signed,
    output logic                             busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]      in_a,
    input  logic [LANES*DATA_WIDTH-1:0]      in_b,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [RESULT_WIDTH-1:0]          res_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  res_level,
    output logic                             done,
    output logic                             cfg_err
);
    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int EXT_WIDTH   = RESULT_WIDTH - DATA_WIDTH;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                   state_reg, state_next;
    logic [RESULT_WIDTH-1:0]  acc_reg;
    logic [LEN_WIDTH-1:0]     cnt_reg;
    logic [LEN_WIDTH-1:0]     len_reg;
    logic                     signed_reg;
    logic                     done_reg;
    logic                     cfg_err_reg;
    logic [PTR_WIDTH-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [LEVEL_WIDTH-1:0]   level_reg;
    logic [RESULT_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];

    logic                     len_ok, start_ok, start_bad;
    logic                     last_beat, fifo_full, accept, push, pop;
    logic [RESULT_WIDTH-1:0]  beat_sum;
    logic [RESULT_WIDTH-1:0]  lane_prod [LANES];
    logic [RESULT_WIDTH-1:0]  partial   [LANES+1];

    // Extending both operands to the full result width makes the truncated product exact
    // for both signed and unsigned modes.
    assign partial[0] = '0;
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0]   a_elem, b_elem;
        logic [RESULT_WIDTH-1:0] a_ext, b_ext;
        assign a_elem = in_a[gi*DATA_WIDTH +: DATA_WIDTH];
        assign b_elem = in_b[gi*DATA_WIDTH +: DATA_WIDTH];
        assign a_ext  = signed_reg ? {{EXT_WIDTH{a_elem[DATA_WIDTH-1]}}, a_elem}
                                   : {{EXT_WIDTH{1'b0}}, a_elem};
        assign b_ext  = signed_reg ? {{EXT_WIDTH{b_elem[DATA_WIDTH-1]}}, b_elem}
                                   : {{EXT_WIDTH{1'b0}}, b_elem};
        assign lane_prod[gi]  = a_ext * b_ext;
        assign partial[gi+1]  = partial[gi] + lane_prod[gi];
    end
    assign beat_sum = partial[LANES];

    assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_WIDTH'(MAX_LEN));
    assign start_ok  = (state_reg == IDLE) && start && len_ok;
    assign start_bad = (state_reg == IDLE) && start && !len_ok;
    assign last_beat = (cnt_reg == len_reg - 1'b1);
    assign fifo_full = (level_reg == LEVEL_WIDTH'(FIFO_DEPTH));
    // Only the final beat needs FIFO space; earlier beats flow regardless of backpressure.
    assign in_ready  = (state_reg == ACCUM) && !(last_beat && fifo_full);
    assign accept    = in_valid && in_ready;
    assign push      = accept && last_beat;
    assign pop       = res_valid && res_ready;

    assign busy      = (state_reg == ACCUM);
    assign res_valid = (level_reg != '0);
    assign res_level = level_reg;
    assign res_data  = res_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign done      = done_reg;
    assign cfg_err   = cfg_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = ACCUM;
            ACCUM:   if (push)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            cnt_reg     <= '0;
            len_reg     <= '0;
            signed_reg  <= 1'b0;
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
        end else begin
            done_reg    <= push;
            cfg_err_reg <= start_bad;
            if (start_ok) begin
                acc_reg    <= '0;
                cnt_reg    <= '0;
                len_reg    <= cfg_len;
                signed_reg <= cfg_signed;
            end else if (accept) begin
                if (last_beat) begin
                    acc_reg <= '0;
                    cnt_reg <= '0;
                end else begin
                    acc_reg <= acc_reg + beat_sum;
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= acc_reg + beat_sum;
    end
endmodule
